// File: rtl/serial_rx_pkg.sv
// Shared types and line levels for the serial frame receiver.
// Pure declarations: no latency, no backpressure.
package serial_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_frame_rx_if.sv
// Serial input, parallel valid/ready output and status of the serial frame receiver.
// master = receiver side, slave = upstream driver plus downstream consumer.
interface serial_frame_rx_if #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
);
    logic                 serial_in;
    logic                 bit_en;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 busy;

    modport master (
        input  serial_in, bit_en, out_ready,
        output out_data, out_valid, frame_err, parity_err, overrun, err_count, busy
    );

    modport slave (
        output serial_in, bit_en, out_ready,
        input  out_data, out_valid, frame_err, parity_err, overrun, err_count, busy
    );
endinterface

// File: rtl/serial_rx_hold.sv
// One-entry valid/ready holding register for received words.
// Latency: load visible the next cycle. Backpressure: a load while full and not draining is dropped and flagged.
module serial_rx_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             ready,
    output logic [WIDTH-1:0] q,
    output logic             full,
    output logic             ovr_det
);

    logic accept;
    logic free;

    assign accept  = full && ready;
    // The slot counts as free when the current word leaves on this same edge.
    assign free    = !full || ready;
    assign ovr_det = load && !free;

    always_ff @(posedge clock) begin
        if (reset) begin
            q    <= '0;
            full <= 1'b0;
        end else if (load && free) begin
            q    <= data;
            full <= 1'b1;
        end else if (accept) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Start/data/[parity]/stop deserialiser, advancing on bit_en; parity stage enabled by SERIAL_RX_PARITY_EN.
// Latency: word and error pulses registered on the stop-bit edge. Backpressure: held word stalls, new word dropped as overrun.
module serial_frame_rx
    import serial_rx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    serial_frame_rx_if.master  bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     shreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 word_ld;
    logic                 fe_det;
    logic                 ovr_det;
    logic                 err_event;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic [ERR_CNT_W-1:0] err_count_q;
`ifdef SERIAL_RX_PARITY_EN
    logic                 par_bit;
    logic                 pe_det;
    logic                 parity_err_q;
`endif

    always_comb begin
        state_nxt = state;
        word_ld   = 1'b0;
        fe_det    = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        pe_det    = 1'b0;
`endif
        if (bus.bit_en) begin
            case (state)
                ST_IDLE: begin
                    if (bus.serial_in == START_LEVEL) state_nxt = ST_DATA;
                end
                ST_DATA: begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end
                end
                ST_PARITY: state_nxt = ST_STOP;
                ST_STOP: begin
                    if (bus.serial_in == STOP_LEVEL) begin
                        state_nxt = ST_IDLE;
`ifdef SERIAL_RX_PARITY_EN
                        // Even parity: transmitted bit equals the XOR of the data bits.
                        if (par_bit != ^shreg) pe_det  = 1'b1;
                        else                   word_ld = 1'b1;
`else
                        word_ld = 1'b1;
`endif
                    end else begin
                        fe_det    = 1'b1;
                        state_nxt = ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (bus.serial_in == IDLE_LEVEL) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
`ifdef SERIAL_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (bus.bit_en) begin
                if (state == ST_IDLE) bit_cnt <= '0;
                if (state == ST_DATA) begin
                    shreg   <= {bus.serial_in, shreg[WIDTH-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
`ifdef SERIAL_RX_PARITY_EN
                if (state == ST_PARITY) par_bit <= bus.serial_in;
`endif
            end
        end
    end

    serial_rx_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clock   (clock),
        .reset   (reset),
        .load    (word_ld),
        .data    (shreg),
        .ready   (bus.out_ready),
        .q       (bus.out_data),
        .full    (bus.out_valid),
        .ovr_det (ovr_det)
    );

`ifdef SERIAL_RX_PARITY_EN
    assign err_event = fe_det || pe_det || ovr_det;
`else
    assign err_event = fe_det || ovr_det;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            frame_err_q <= fe_det;
            overrun_q   <= ovr_det;
            if (err_event && (err_count_q != '1)) err_count_q <= err_count_q + 1'b1;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge clock) begin
        if (reset) parity_err_q <= 1'b0;
        else       parity_err_q <= pe_det;
    end
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.err_count = err_count_q;
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomised and directed bench for serial_frame_rx against a frame-level outcome model.
module tb_serial_frame_rx;

    localparam int W  = 8;
    localparam int EW = 8;

    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    serial_frame_rx_if #(.WIDTH(W), .ERR_CNT_W(EW)) bus ();

    serial_frame_rx #(.WIDTH(W), .ERR_CNT_W(EW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: collects accepted words and pulse counts, flags protocol breaches.
    logic [W-1:0] got[$];
    int fe_pulses = 0, pe_pulses = 0, ov_pulses = 0, long_pulses = 0, hold_viol = 0;
    logic pv = 0, pr = 0, pfe = 0, ppe = 0, pov = 0;
    logic [W-1:0] pd = '0;

    always @(negedge clock) begin
        if (reset) begin
            pv = 0; pr = 0; pfe = 0; ppe = 0; pov = 0;
        end else begin
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            if (bus.frame_err)  fe_pulses++;
            if (bus.parity_err) pe_pulses++;
            if (bus.overrun)    ov_pulses++;
            if ((bus.frame_err && pfe) || (bus.parity_err && ppe) || (bus.overrun && pov)) long_pulses++;
            if (pv && !pr && (!bus.out_valid || bus.out_data !== pd)) hold_viol++;
            pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data;
            pfe = bus.frame_err; ppe = bus.parity_err; pov = bus.overrun;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b, input int period);
        bus.serial_in = b;
        bus.bit_en    = 1'b1;
        tick();
        bus.bit_en = 1'b0;
        for (int i = 1; i < period; i++) begin
            bus.serial_in = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    task automatic send_head(input logic [W-1:0] d, input logic par, input int period);
        send_bit(1'b0, period);
        for (int i = 0; i < W; i++) send_bit(d[i], period);
`ifdef SERIAL_RX_PARITY_EN
        send_bit(par, period);
`else
        if (par === 1'bz) $display("unused parity argument");
`endif
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic par, input logic stop, input int period);
        send_head(d, par, period);
        send_bit(stop, period);
    endtask

    task automatic do_reset();
        bus.serial_in = 1'b1;
        bus.bit_en    = 1'b0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.serial_in = 1'b0;
        bus.bit_en    = 1'b1;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        n_checks++; if (bus.out_data !== '0)  begin n_fail++; $display("FAIL reset_out_data got %h want 00", bus.out_data); end
        n_checks++; if (bus.out_valid !== 0)  begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.frame_err !== 0)  begin n_fail++; $display("FAIL reset_frame_err got %b want 0", bus.frame_err); end
        n_checks++; if (bus.parity_err !== 0) begin n_fail++; $display("FAIL reset_parity_err got %b want 0", bus.parity_err); end
        n_checks++; if (bus.overrun !== 0)    begin n_fail++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
        n_checks++; if (bus.err_count !== '0) begin n_fail++; $display("FAIL reset_err_count got %0d want 0", bus.err_count); end
        n_checks++; if (bus.busy !== 0)       begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        do_reset();
    endtask

    task automatic test_basic();
        int base;
        do_reset();
        base = got.size();
        send_head(8'h5A, ^8'h5A, 1);
        n_checks++; if (bus.out_valid !== 0) begin n_fail++; $display("FAIL basic_early_valid got %b want 0", bus.out_valid); end
        send_bit(1'b1, 1);
        n_checks++; if (bus.out_valid !== 1)     begin n_fail++; $display("FAIL basic_valid got %b want 1", bus.out_valid); end
        n_checks++; if (bus.out_data !== 8'h5A)  begin n_fail++; $display("FAIL basic_data got %h want 5a", bus.out_data); end
        n_checks++; if ({bus.frame_err, bus.parity_err, bus.overrun} !== 3'b000)
            begin n_fail++; $display("FAIL basic_errors got %b want 000", {bus.frame_err, bus.parity_err, bus.overrun}); end
        n_checks++; if (bus.busy !== 0) begin n_fail++; $display("FAIL basic_busy got %b want 0", bus.busy); end
        tick();
        n_checks++; if (bus.out_valid !== 0) begin n_fail++; $display("FAIL basic_drop_valid got %b want 0", bus.out_valid); end
        n_checks++; if (got.size() != base + 1 || got[base] !== 8'h5A)
            begin n_fail++; $display("FAIL basic_accepted got %0d words want 1 word 5a", got.size() - base); end
    endtask

    task automatic test_frame_err();
        int base, fe0;
        do_reset();
        base = got.size();
        fe0  = fe_pulses;
        send_frame(8'h33, ^8'h33, 1'b0, 1);
        n_checks++; if (bus.frame_err !== 1) begin n_fail++; $display("FAIL ferr_pulse got %b want 1", bus.frame_err); end
        n_checks++; if (bus.out_valid !== 0) begin n_fail++; $display("FAIL ferr_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.err_count !== 1) begin n_fail++; $display("FAIL ferr_count got %0d want 1", bus.err_count); end
        tick();
        n_checks++; if (bus.frame_err !== 0) begin n_fail++; $display("FAIL ferr_width got %b want 0", bus.frame_err); end
        send_bit(1'b0, 1);
        send_bit(1'b0, 2);
        n_checks++; if (bus.busy !== 1) begin n_fail++; $display("FAIL ferr_wait_busy got %b want 1", bus.busy); end
        send_bit(1'b1, 1);
        n_checks++; if (bus.busy !== 0) begin n_fail++; $display("FAIL ferr_recover_busy got %b want 0", bus.busy); end
        send_frame(8'h96, ^8'h96, 1'b1, 1);
        tick();
        n_checks++; if (got.size() != base + 1 || got[base] !== 8'h96)
            begin n_fail++; $display("FAIL ferr_next_frame got %0d words want 1 word 96", got.size() - base); end
        n_checks++; if (fe_pulses - fe0 != 1 || bus.err_count !== 1)
            begin n_fail++; $display("FAIL ferr_totals got pulses %0d count %0d want 1 1", fe_pulses - fe0, bus.err_count); end
    endtask

    task automatic test_overrun();
        int base;
        do_reset();
        bus.out_ready = 1'b0;
        send_frame(8'h11, ^8'h11, 1'b1, 1);
        n_checks++; if (bus.out_valid !== 1 || bus.out_data !== 8'h11)
            begin n_fail++; $display("FAIL ovr_first got v=%b d=%h want v=1 d=11", bus.out_valid, bus.out_data); end
        send_frame(8'h22, ^8'h22, 1'b1, 1);
        n_checks++; if (bus.overrun !== 1)      begin n_fail++; $display("FAIL ovr_pulse got %b want 1", bus.overrun); end
        n_checks++; if (bus.out_data !== 8'h11) begin n_fail++; $display("FAIL ovr_data_held got %h want 11", bus.out_data); end
        n_checks++; if (bus.err_count !== 1)    begin n_fail++; $display("FAIL ovr_count got %0d want 1", bus.err_count); end
        tick();
        n_checks++; if (bus.overrun !== 0) begin n_fail++; $display("FAIL ovr_width got %b want 0", bus.overrun); end
        bus.out_ready = 1'b1;
        base = got.size();
        tick();
        n_checks++; if (got.size() != base + 1 || got[base] !== 8'h11)
            begin n_fail++; $display("FAIL ovr_accept got %0d words want 1 word 11", got.size() - base); end
        n_checks++; if (bus.out_valid !== 0) begin n_fail++; $display("FAIL ovr_drop_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        int base, ov0;
        do_reset();
        ov0 = ov_pulses;
        bus.out_ready = 1'b0;
        send_frame(8'h3C, ^8'h3C, 1'b1, 1);
        send_head(8'hE7, ^8'hE7, 1);
        bus.out_ready = 1'b1;
        base = got.size();
        send_bit(1'b1, 1);
        bus.out_ready = 1'b0;
        n_checks++; if (got.size() != base + 1 || got[base] !== 8'h3C)
            begin n_fail++; $display("FAIL b2b_old_word got %0d words want 1 word 3c", got.size() - base); end
        n_checks++; if (bus.out_valid !== 1 || bus.out_data !== 8'hE7)
            begin n_fail++; $display("FAIL b2b_new_word got v=%b d=%h want v=1 d=e7", bus.out_valid, bus.out_data); end
        n_checks++; if (bus.overrun !== 0 || ov_pulses != ov0)
            begin n_fail++; $display("FAIL b2b_no_overrun got %b want 0", bus.overrun); end
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_slow_bit_en();
        logic bits[$];
        logic [W-1:0] d;
        int busy_low, base;
        d = 8'hA5;
        do_reset();
        base = got.size();
        busy_low = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(d[i]);
`ifdef SERIAL_RX_PARITY_EN
        bits.push_back(^d);
`endif
        bits.push_back(1'b1);
        for (int k = 0; k < bits.size(); k++) begin
            bus.serial_in = bits[k];
            bus.bit_en    = 1'b1;
            tick();
            if (k == bits.size() - 1) begin
                n_checks++; if (bus.out_valid !== 1 || bus.out_data !== 8'hA5)
                    begin n_fail++; $display("FAIL slow_data got v=%b d=%h want v=1 d=a5", bus.out_valid, bus.out_data); end
            end else if (bus.busy !== 1) busy_low++;
            bus.bit_en = 1'b0;
            for (int g = 0; g < 3; g++) begin
                bus.serial_in = 1'($urandom_range(0, 1));
                tick();
                if (k != bits.size() - 1 && bus.busy !== 1) busy_low++;
            end
        end
        n_checks++; if (busy_low != 0) begin n_fail++; $display("FAIL slow_busy got %0d low cycles want 0", busy_low); end
        n_checks++; if (got.size() != base + 1) begin n_fail++; $display("FAIL slow_count got %0d words want 1", got.size() - base); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_bit(1'b0, 1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1);
        reset = 1'b1;
        tick();
        n_checks++; if (bus.busy !== 0 || bus.out_valid !== 0)
            begin n_fail++; $display("FAIL midrst_state got busy=%b v=%b want 0 0", bus.busy, bus.out_valid); end
        reset = 1'b0;
        bus.serial_in = 1'b1;
        tick();
        send_frame(8'hC3, ^8'hC3, 1'b1, 1);
        n_checks++; if (bus.out_valid !== 1 || bus.out_data !== 8'hC3 || bus.err_count !== 0)
            begin n_fail++; $display("FAIL midrst_frame got v=%b d=%h e=%0d want v=1 d=c3 e=0", bus.out_valid, bus.out_data, bus.err_count); end
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] exp[$];
        logic [W-1:0] d;
        int base, fe0, pe0, ov0, nbad, npe, p;
        logic bad_stop, bad_par;
        do_reset();
        base = got.size();
        fe0 = fe_pulses; pe0 = pe_pulses; ov0 = ov_pulses;
        nbad = 0; npe = 0;
        for (int f = 0; f < 40; f++) begin
            d        = W'($urandom);
            p        = $urandom_range(1, 3);
            bad_stop = ($urandom_range(0, 3) == 0);
`ifdef SERIAL_RX_PARITY_EN
            bad_par  = ($urandom_range(0, 3) == 0);
`else
            bad_par  = 1'b0;
`endif
            send_frame(d, (^d) ^ bad_par, !bad_stop, p);
            if (bad_stop) begin
                nbad++;
                send_bit(1'b1, p);
            end else if (bad_par) npe++;
            else exp.push_back(d);
        end
        repeat (3) tick();
        n_checks++; if (got.size() - base != exp.size())
            begin n_fail++; $display("FAIL rand_count got %0d words want %0d", got.size() - base, exp.size()); end
        for (int i = 0; i < exp.size() && base + i < got.size(); i++) begin
            n_checks++; if (got[base + i] !== exp[i])
                begin n_fail++; $display("FAIL rand_word[%0d] got %h want %h", i, got[base + i], exp[i]); end
        end
        n_checks++; if (fe_pulses - fe0 != nbad) begin n_fail++; $display("FAIL rand_frame_err got %0d want %0d", fe_pulses - fe0, nbad); end
        n_checks++; if (pe_pulses - pe0 != npe)  begin n_fail++; $display("FAIL rand_parity_err got %0d want %0d", pe_pulses - pe0, npe); end
        n_checks++; if (ov_pulses != ov0)        begin n_fail++; $display("FAIL rand_overrun got %0d want 0", ov_pulses - ov0); end
        n_checks++; if (bus.err_count !== EW'(nbad + npe))
            begin n_fail++; $display("FAIL rand_err_count got %0d want %0d", bus.err_count, nbad + npe); end
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic test_parity();
        do_reset();
        send_frame(8'h5A, 1'b0, 1'b1, 1);
        n_checks++; if (bus.out_valid !== 1 || bus.out_data !== 8'h5A || bus.parity_err !== 0)
            begin n_fail++; $display("FAIL par_good got v=%b d=%h pe=%b want 1 5a 0", bus.out_valid, bus.out_data, bus.parity_err); end
        tick();
        send_frame(8'h5A, 1'b1, 1'b1, 1);
        n_checks++; if (bus.parity_err !== 1 || bus.out_valid !== 0 || bus.err_count !== 1)
            begin n_fail++; $display("FAIL par_bad got pe=%b v=%b e=%0d want 1 0 1", bus.parity_err, bus.out_valid, bus.err_count); end
        tick();
        send_frame(8'h5A, 1'b1, 1'b0, 1);
        n_checks++; if (bus.frame_err !== 1 || bus.parity_err !== 0 || bus.err_count !== 2)
            begin n_fail++; $display("FAIL par_stop got fe=%b pe=%b e=%0d want 1 0 2", bus.frame_err, bus.parity_err, bus.err_count); end
        send_bit(1'b1, 1);
    endtask
`endif

    task automatic test_saturate();
        logic [W-1:0] d;
        int fe0;
        do_reset();
        fe0 = fe_pulses;
        for (int i = 0; i < 300; i++) begin
            d = W'($urandom);
            send_frame(d, ^d, 1'b0, 1);
            send_bit(1'b1, 1);
        end
        n_checks++; if (bus.err_count !== {EW{1'b1}})
            begin n_fail++; $display("FAIL sat_count got %0d want 255", bus.err_count); end
        n_checks++; if (fe_pulses - fe0 != 300)
            begin n_fail++; $display("FAIL sat_pulses got %0d want 300", fe_pulses - fe0); end
    endtask

    task automatic test_protocol();
        n_checks++; if (long_pulses != 0) begin n_fail++; $display("FAIL pulse_width got %0d long pulses want 0", long_pulses); end
        n_checks++; if (hold_viol != 0)   begin n_fail++; $display("FAIL hold_stable got %0d breaches want 0", hold_viol); end
    endtask

    initial begin
        bus.serial_in = 1'b1;
        bus.bit_en    = 1'b0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        test_reset();
        test_basic();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_slow_bit_en();
        test_mid_reset();
        test_random();
`ifdef SERIAL_RX_PARITY_EN
        test_parity();
`endif
        test_saturate();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
